// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for the mem block. Aligned requests take one mem beat;
// misaligned half/word requests are split into byte beats and reassembled.
package mem_lsu_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef struct packed {
        logic [1:0] access_size;
        logic       unsigned_access;
        logic       read_write;
    } mem_params_t;
endpackage

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic        req_write,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output mem_params_t mem_params
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] SPLIT  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        write_q;
    logic        fault_q;
    logic [1:0]  beat;
    logic [31:0] result;

    logic        misaligned;
    logic        last_beat;
    logic [4:0]  beat_shift;
    logic [31:0] wdata_shifted;
    logic [31:0] merged;

    always_comb begin
        case (req_size)
            SIZE_HALF: misaligned = req_addr[0];
            SIZE_WORD: misaligned = |req_addr[1:0];
            default:   misaligned = 1'b0;
        endcase
    end

    assign beat_shift    = {beat, 3'b000};
    assign last_beat     = (size_q == SIZE_HALF) ? (beat == 2'd1) : (beat == 2'd3);
    assign wdata_shifted = wdata_q >> beat_shift;

    // Byte beats fill the result LSB-first; a split half is extended from bit 15 on its final beat.
    always_comb begin
        merged = (result & ~(32'h0000_00FF << beat_shift))
               | ({24'd0, mem_data_out[7:0]} << beat_shift);
        if (last_beat && size_q == SIZE_HALF) begin
            merged[31:16] = unsigned_q ? 16'd0 : {16{merged[15]}};
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? result : 32'd0;
    assign rsp_fault = rsp_valid & fault_q;

    // Outside a beat the port idles as a word read of address 0, so mem never sees a stray write.
    always_comb begin
        mem_address = 32'd0;
        mem_data_in = 32'd0;
        mem_params  = '{access_size: SIZE_WORD, unsigned_access: 1'b0, read_write: 1'b1};
        case (state)
            ACCESS: begin
                mem_address = addr_q;
                mem_data_in = wdata_q;
                mem_params  = '{access_size: size_q, unsigned_access: unsigned_q,
                                read_write: ~write_q};
            end
            SPLIT: begin
                mem_address = addr_q + {30'd0, beat};
                mem_data_in = {24'd0, wdata_shifted[7:0]};
                mem_params  = '{access_size: SIZE_BYTE, unsigned_access: 1'b1,
                                read_write: ~write_q};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= SIZE_WORD;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            fault_q    <= 1'b0;
            beat       <= 2'd0;
            result     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        beat       <= 2'd0;
                        result     <= 32'd0;
                        fault_q    <= 1'b0;
                        if (req_size == SIZE_RSVD || (misaligned && !SPLIT_MISALIGNED)) begin
                            fault_q <= 1'b1;
                            state   <= RESP;
                        end else if (misaligned) begin
                            state <= SPLIT;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        result <= mem_data_out;
                    end
                    state <= RESP;
                end
                SPLIT: begin
                    if (!write_q) begin
                        result <= merged;
                    end
                    if (last_beat) begin
                        state <= RESP;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: drives mem_lsu (split and no-split builds) against a byte-array mem and a reference model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_write;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    mem_params_t mem_params;

    logic        ns_req_ready;
    logic        ns_rsp_valid;
    logic [31:0] ns_rsp_rdata;
    logic        ns_rsp_fault;
    logic [31:0] ns_mem_address;
    logic [31:0] ns_mem_data_in;
    logic [31:0] ns_mem_data_out;
    mem_params_t ns_mem_params;

    int n_checks    = 0;
    int n_fail      = 0;
    int wr_beats    = 0;
    int ns_wr_beats = 0;
    int rsp_pulses  = 0;

    logic [7:0]  mem_bytes [0:4095];
    logic [7:0]  ref_bytes [0:4095];
    bit          mem_loaded = 1'b0;
    logic [31:0] mem_word;

    assign ns_mem_data_out = 32'd0;

    mem_lsu #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_write(req_write), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_params(mem_params)
    );

    mem_lsu #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(ns_req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_write(req_write), .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata),
        .rsp_fault(ns_rsp_fault), .mem_address(ns_mem_address), .mem_data_in(ns_mem_data_in),
        .mem_data_out(ns_mem_data_out), .mem_params(ns_mem_params)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29) ^ (i >> 3) ^ 8'h5A);
    endfunction

    function automatic int size_bytes(input logic [1:0] size);
        return (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : 4;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (size == SIZE_HALF && addr[0]) || (size == SIZE_WORD && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        logic [31:0] val = 32'd0;
        int n = size_bytes(size);
        for (int k = 0; k < n; k++) begin
            val = val | (32'(ref_bytes[12'(addr + 32'(k))]) << (8 * k));
        end
        if (!uns && n < 4 && val[8 * n - 1]) begin
            val = val | (32'hFFFF_FFFF << (8 * n));
        end
        return val;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input int n);
        for (int k = 0; k < n; k++) begin
            ref_bytes[12'(addr + 32'(k))] = 8'(wdata >> (8 * k));
        end
    endtask

    // Behavioural mem: combinational little-endian read with extension, byte-lane writes on the edge.
    always_comb begin
        mem_word = {mem_bytes[12'(mem_address + 32'd3)], mem_bytes[12'(mem_address + 32'd2)],
                    mem_bytes[12'(mem_address + 32'd1)], mem_bytes[mem_address[11:0]]};
        case (mem_params.access_size)
            SIZE_BYTE: mem_data_out = {{24{!mem_params.unsigned_access && mem_word[7]}}, mem_word[7:0]};
            SIZE_HALF: mem_data_out = {{16{!mem_params.unsigned_access && mem_word[15]}}, mem_word[15:0]};
            default:   mem_data_out = mem_word;
        endcase
    end

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) begin
                mem_bytes[i] <= init_byte(i);
            end
            mem_loaded <= 1'b1;
        end else if (reset && mem_params.read_write == 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (k < size_bytes(mem_params.access_size)) begin
                    mem_bytes[12'(mem_address + 32'(k))] <= mem_data_in[8 * k +: 8];
                end
            end
        end
    end

    always @(posedge clock) begin
        if (mem_params.read_write == 1'b0) wr_beats++;
        if (ns_mem_params.read_write == 1'b0) ns_wr_beats++;
        if (rsp_valid) rsp_pulses++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns, input logic wr,
                                  output logic [31:0] got);
        logic        mis, exp_fault, exp_ns_fault, fault, ns_fault;
        logic [31:0] exp_rdata, rdata, ns_rdata;
        int          n, exp_cycles, exp_beats, cycles, pulses, ns_pulses, wr0, ns_wr0;
        n            = size_bytes(size);
        mis          = is_misaligned(addr, size);
        exp_fault    = (size == SIZE_RSVD);
        exp_ns_fault = exp_fault || mis;
        exp_rdata    = (exp_fault || wr) ? 32'd0 : ref_load(addr, size, uns);
        exp_cycles   = exp_fault ? 2 : (mis ? n + 2 : 3);
        exp_beats    = (wr && !exp_fault) ? (mis ? n : 1) : 0;

        @(negedge clock);
        check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
        check_output({tag, "_ns_ready"}, 32'(ns_req_ready), 32'd1);
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_write    = wr;
        req_valid    = 1'b1;
        wr0          = wr_beats;
        ns_wr0       = ns_wr_beats;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        cycles = 1; pulses = 0; ns_pulses = 0;
        rdata = 32'hxxxx_xxxx; fault = 1'bx; ns_rdata = 32'hxxxx_xxxx; ns_fault = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                pulses++;
                rdata = rsp_rdata;
                fault = rsp_fault;
            end
            if (ns_rsp_valid) begin
                ns_pulses++;
                ns_rdata = ns_rsp_rdata;
                ns_fault = ns_rsp_fault;
            end
            if (req_ready) break;
            @(posedge clock);
            cycles++;
        end
        check_output({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        check_output({tag, "_rdata"}, rdata, exp_rdata);
        check_output({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        check_output({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check_output({tag, "_pulses"}, 32'(pulses), 32'd1);
        check_output({tag, "_wbeats"}, 32'(wr_beats - wr0), 32'(exp_beats));
        check_output({tag, "_ns_fault"}, 32'(ns_fault), 32'(exp_ns_fault));
        check_output({tag, "_ns_rdata"}, ns_rdata, 32'd0);
        check_output({tag, "_ns_pulses"}, 32'(ns_pulses), 32'd1);
        check_output({tag, "_ns_wbeats"}, 32'(ns_wr_beats - ns_wr0),
                     32'((wr && !exp_ns_fault) ? 1 : 0));
        if (wr && !exp_fault) ref_store(addr, wdata, n);
        got = rdata;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] ra;
        int          p0;
        int          bad;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = init_byte(i);
        reset = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = SIZE_WORD; req_unsigned = 1'b0; req_write = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_ready", 32'(req_ready), 32'd1);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rdata", rsp_rdata, 32'd0);
        check_output("rst_fault", 32'(rsp_fault), 32'd0);
        check_output("rst_mem_addr", mem_address, 32'd0);
        check_output("rst_mem_din", mem_data_in, 32'd0);
        check_output("rst_params", 32'(mem_params), 32'(4'b1001));
        @(negedge clock);
        reset = 1'b1;

        apply_stimulus("st_word", 32'h100, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 1'b1, got);
        apply_stimulus("ld_word", 32'h100, 32'h0, SIZE_WORD, 1'b0, 1'b0, got);
        check_output("spec_ld_word", got, 32'hDEAD_BEEF);
        apply_stimulus("ld_byte_s", 32'h100, 32'h0, SIZE_BYTE, 1'b0, 1'b0, got);
        check_output("spec_ld_byte_s", got, 32'hFFFF_FFEF);
        apply_stimulus("ld_byte_u", 32'h100, 32'h0, SIZE_BYTE, 1'b1, 1'b0, got);
        check_output("spec_ld_byte_u", got, 32'h0000_00EF);

        apply_stimulus("st_mis_word", 32'h201, 32'h1122_3344, SIZE_WORD, 1'b0, 1'b1, got);
        check_output("mem_201", 32'(mem_bytes[12'h201]), 32'h44);
        check_output("mem_202", 32'(mem_bytes[12'h202]), 32'h33);
        check_output("mem_203", 32'(mem_bytes[12'h203]), 32'h22);
        check_output("mem_204", 32'(mem_bytes[12'h204]), 32'h11);
        apply_stimulus("ld_mis_word", 32'h201, 32'h0, SIZE_WORD, 1'b0, 1'b0, got);
        check_output("spec_ld_mis_word", got, 32'h1122_3344);

        apply_stimulus("st_b203", 32'h203, 32'h34, SIZE_BYTE, 1'b0, 1'b1, got);
        apply_stimulus("st_b204", 32'h204, 32'h80, SIZE_BYTE, 1'b0, 1'b1, got);
        apply_stimulus("ld_mis_half_s", 32'h203, 32'h0, SIZE_HALF, 1'b0, 1'b0, got);
        check_output("spec_half_s", got, 32'hFFFF_8034);
        apply_stimulus("ld_mis_half_u", 32'h203, 32'h0, SIZE_HALF, 1'b1, 1'b0, got);
        check_output("spec_half_u", got, 32'h0000_8034);

        apply_stimulus("rsvd_load", 32'h300, 32'h0, SIZE_RSVD, 1'b0, 1'b0, got);
        apply_stimulus("rsvd_store", 32'h300, 32'hA5A5_A5A5, SIZE_RSVD, 1'b0, 1'b1, got);
        apply_stimulus("st_wrap", 32'hFFFF_FFFE, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 1'b1, got);
        apply_stimulus("ld_wrap", 32'hFFFF_FFFE, 32'h0, SIZE_WORD, 1'b0, 1'b0, got);
        check_output("spec_ld_wrap", got, 32'hCAFE_F00D);

        for (int t = 0; t < 40; t++) begin
            ra = 32'h600 + 32'($urandom_range(0, 255));
            apply_stimulus("rand", ra, $urandom, 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
        end

        // Reset lands during beat 2 of a split word store: first two bytes stick, the rest do not.
        @(negedge clock);
        req_addr = 32'h501; req_wdata = 32'hAABB_CCDD; req_size = SIZE_WORD;
        req_unsigned = 1'b0; req_write = 1'b1; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        p0 = rsp_pulses;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_ready", 32'(req_ready), 32'd1);
        check_output("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("mid_rst_params", 32'(mem_params), 32'(4'b1001));
        check_output("mid_rst_addr", mem_address, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("mid_rst_no_rsp", 32'(rsp_pulses - p0), 32'd0);
        check_output("mid_rst_ready_after", 32'(req_ready), 32'd1);
        check_output("mid_rst_b0", 32'(mem_bytes[12'h501]), 32'hDD);
        check_output("mid_rst_b1", 32'(mem_bytes[12'h502]), 32'hCC);
        check_output("mid_rst_b2", 32'(mem_bytes[12'h503]), 32'(ref_bytes[12'h503]));
        check_output("mid_rst_b3", 32'(mem_bytes[12'h504]), 32'(ref_bytes[12'h504]));
        ref_store(32'h501, 32'hAABB_CCDD, 2);

        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem_bytes[i] !== ref_bytes[i]) bad++;
        end
        check_output("mem_sweep", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
